// File: rtl/cpu_run_monitor.sv
// Watches a CPU program run: counts cycles and fetches, detects halt, waits for register_v0 to
// settle, then reports pass/fail against a golden value or a timeout if halt never arrives.
module cpu_run_monitor #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = '0,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int unsigned       TIMEOUT      = 256,
  parameter int unsigned       CNT_W        = 16,
  parameter int unsigned       HALT_MODE    = 0,
  parameter int unsigned       SETTLE       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpu_active,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic [DATA_W-1:0] register_v0,
  input  logic [DATA_W-1:0] expected,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  fetch_count,
  output logic [DATA_W-1:0] observed_v0
);

  typedef enum logic [2:0] {StIdle, StRun, StSettle, StPass, StFail, StTimeout} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d, fetch_q, fetch_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic              first_q, first_d;
  logic              active_q;
  logic [DATA_W-1:0] exp_q, exp_d, snap_q, snap_d, obs_q, obs_d;
  logic [3:0]        settle_q, settle_d;
  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d, timeout_q, timeout_d;

  logic [CNT_W-1:0]  cycle_inc, fetch_inc;
  logic              halt;

  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
  assign fetch_inc = (fetch_q == '1) ? fetch_q : fetch_q + 1'b1;

  // Mode 0: address match, mode 1: registered falling edge of cpu_active, mode 2: either.
  assign halt = ((HALT_MODE != 1) && (instr_address == HALT_ADDR)) ||
                ((HALT_MODE != 0) && active_q && !cpu_active);

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    fetch_d     = fetch_q;
    prev_addr_d = prev_addr_q;
    first_d     = first_q;
    exp_d       = exp_q;
    snap_d      = snap_q;
    settle_d    = settle_q;
    obs_d       = obs_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;

    if (start) begin
      state_d     = StRun;
      cycle_d     = '0;
      fetch_d     = '0;
      prev_addr_d = RESET_VECTOR;
      first_d     = 1'b1;
      exp_d       = expected;
      snap_d      = '0;
      settle_d    = '0;
      obs_d       = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          cycle_d     = cycle_inc;
          prev_addr_d = instr_address;
          first_d     = 1'b0;
          if (first_q || (instr_address != prev_addr_q)) fetch_d = fetch_inc;
          // Halt takes precedence over a timeout landing on the same cycle.
          if (halt) begin
            state_d  = StSettle;
            settle_d = 4'd1;
            snap_d   = register_v0;
          end else if (cycle_inc == CNT_W'(TIMEOUT)) begin
            state_d   = StTimeout;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        StSettle: begin
          if (settle_q == 4'(SETTLE)) begin
            obs_d  = snap_q;
            done_d = 1'b1;
            if (snap_q == exp_q) begin
              state_d = StPass;
              pass_d  = 1'b1;
            end else begin
              state_d = StFail;
              fail_d  = 1'b1;
            end
          end else if (register_v0 == snap_q) begin
            settle_d = settle_q + 4'd1;
          end else begin
            snap_d   = register_v0;
            settle_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cycle_q     <= '0;
      fetch_q     <= '0;
      prev_addr_q <= '0;
      first_q     <= 1'b0;
      active_q    <= 1'b0;
      exp_q       <= '0;
      snap_q      <= '0;
      settle_q    <= '0;
      obs_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      fetch_q     <= fetch_d;
      prev_addr_q <= prev_addr_d;
      first_q     <= first_d;
      active_q    <= cpu_active;
      exp_q       <= exp_d;
      snap_q      <= snap_d;
      settle_q    <= settle_d;
      obs_q       <= obs_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign fetch_count = fetch_q;
  assign observed_v0 = obs_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench: four monitor instances with different parameters share one stimulus bus;
// each directed run pushes its hand-computed verdict and a monitor pops it when done rises.
module tb_cpu_run_monitor;

  typedef struct {
    string       name;
    logic [31:0] p, f, t, cyc, fet, obs;
    int          due;
  } exp_t;

  logic        clk, reset, start, cpu_active;
  logic [31:0] instr_address, register_v0, expected;
  logic        done_w [4], pass_w [4], fail_w [4], to_w [4];
  logic [15:0] cyc_w [4], fet_w [4];
  logic [31:0] obs_w [4];

  logic        m_done, m_pass, m_fail, m_to;
  logic [15:0] m_cyc, m_fet;
  logic [31:0] m_obs;

  int   sel = 0;
  int   tb_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  cpu_run_monitor u_dut0 (
    .clk(clk), .reset(reset), .start(start), .cpu_active(cpu_active),
    .instr_address(instr_address), .register_v0(register_v0), .expected(expected),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(to_w[0]),
    .cycle_count(cyc_w[0]), .fetch_count(fet_w[0]), .observed_v0(obs_w[0]));

  cpu_run_monitor #(.TIMEOUT(20)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .cpu_active(cpu_active),
    .instr_address(instr_address), .register_v0(register_v0), .expected(expected),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(to_w[1]),
    .cycle_count(cyc_w[1]), .fetch_count(fet_w[1]), .observed_v0(obs_w[1]));

  cpu_run_monitor #(.SETTLE(3)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .cpu_active(cpu_active),
    .instr_address(instr_address), .register_v0(register_v0), .expected(expected),
    .done(done_w[2]), .pass(pass_w[2]), .fail(fail_w[2]), .timeout(to_w[2]),
    .cycle_count(cyc_w[2]), .fetch_count(fet_w[2]), .observed_v0(obs_w[2]));

  cpu_run_monitor #(.HALT_MODE(1), .TIMEOUT(20)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .cpu_active(cpu_active),
    .instr_address(instr_address), .register_v0(register_v0), .expected(expected),
    .done(done_w[3]), .pass(pass_w[3]), .fail(fail_w[3]), .timeout(to_w[3]),
    .cycle_count(cyc_w[3]), .fetch_count(fet_w[3]), .observed_v0(obs_w[3]));

  always_comb begin
    m_done = done_w[sel];
    m_pass = pass_w[sel];
    m_fail = fail_w[sel];
    m_to   = to_w[sel];
    m_cyc  = cyc_w[sel];
    m_fet  = fet_w[sel];
    m_obs  = obs_w[sel];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] p, input logic [31:0] f,
                      input logic [31:0] t, input logic [31:0] cyc, input logic [31:0] fet,
                      input logic [31:0] obs, input int due);
    exp_t e;
    e.name = nm; e.p = p; e.f = f; e.t = t; e.cyc = cyc; e.fet = fet; e.obs = obs; e.due = due;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per rising edge of the selected instance's done.
  always begin : monitor
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (m_done && !done_prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_verdict", 32'(m_done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_pass"},    32'(m_pass), e.p);
          chk({e.name, "_fail"},    32'(m_fail), e.f);
          chk({e.name, "_timeout"}, 32'(m_to),   e.t);
          chk({e.name, "_cycles"},  32'(m_cyc),  e.cyc);
          chk({e.name, "_fetches"}, 32'(m_fet),  e.fet);
          chk({e.name, "_obs_v0"},  m_obs,       e.obs);
          chk({e.name, "_latency"}, 32'(tb_cyc), 32'(e.due));
        end
      end
      done_prev = m_done;
    end
  end

  task automatic do_start(input int s, input logic [31:0] ex, output int t0);
    @(negedge clk);
    sel      = s;
    expected = ex;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = tb_cyc;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_verdict_seen"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1);
  end

  initial begin
    int t0;
    reset = 1'b0; start = 1'b0; cpu_active = 1'b1;
    instr_address = '0; register_v0 = '0; expected = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",    32'(m_done), 0);
    chk("rst_pass",    32'(m_pass), 0);
    chk("rst_fail",    32'(m_fail), 0);
    chk("rst_timeout", 32'(m_to),   0);
    chk("rst_cycles",  32'(m_cyc),  0);
    chk("rst_fetches", 32'(m_fet),  0);
    chk("rst_obs",     m_obs,       0);
    reset = 1'b1;

    // 16 sequential fetches then halt address: 17 RUN cycles, decision 2 cycles later.
    register_v0 = 144;
    do_start(0, 144, t0);
    push("prog_pass", 1, 0, 0, 17, 17, 144, t0 + 19);
    for (int i = 0; i < 16; i++) begin
      instr_address = 32'hBFC0_0000 + 32'(i * 4);
      @(negedge clk);
    end
    instr_address = '0;
    drain("prog_pass");
    repeat (4) @(negedge clk);
    chk("sticky_pass", 32'(m_pass), 1);

    register_v0 = 143;
    do_start(0, 144, t0);
    push("prog_fail", 0, 1, 0, 17, 17, 143, t0 + 19);
    for (int i = 0; i < 16; i++) begin
      instr_address = 32'hBFC0_0000 + 32'(i * 4);
      @(negedge clk);
    end
    instr_address = '0;
    drain("prog_fail");

    // Address never reaches halt; timeout after 20 RUN cycles with one distinct fetch.
    do_start(1, 5, t0);
    push("timeout", 0, 0, 1, 20, 1, 0, t0 + 20);
    instr_address = 32'hBFC0_0000;
    drain("timeout");

    // v0 unsettled at halt: 100 then 144 held; PASS three cycles after 144 is first sampled.
    register_v0 = 100;
    do_start(2, 144, t0);
    push("settle3", 1, 0, 0, 3, 3, 144, t0 + 7);
    instr_address = 32'hBFC0_0000;
    @(negedge clk);
    instr_address = 32'hBFC0_0004;
    @(negedge clk);
    instr_address = '0;
    @(negedge clk);
    register_v0 = 144;
    drain("settle3");

    // cpu_active falls on the RUN cycle that reaches TIMEOUT: halt wins.
    register_v0 = 9;
    cpu_active  = 1'b1;
    do_start(3, 9, t0);
    push("fall_vs_to", 1, 0, 0, 20, 1, 9, t0 + 22);
    instr_address = 32'hBFC0_0000;
    repeat (19) @(negedge clk);
    cpu_active = 1'b0;
    drain("fall_vs_to");
    cpu_active = 1'b1;

    // Reset mid-run aborts without a verdict; a fresh start then completes.
    register_v0 = 7;
    do_start(0, 7, t0);
    instr_address = 32'hBFC0_0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_cycles",  32'(m_cyc),  0);
    chk("midrst_fetches", 32'(m_fet),  0);
    chk("midrst_done",    32'(m_done), 0);
    @(negedge clk);
    reset = 1'b1;
    instr_address = '0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", 32'(m_done), 0);
    do_start(0, 7, t0);
    push("rerun", 1, 0, 0, 4, 4, 7, t0 + 6);
    instr_address = 32'hBFC0_0010;
    @(negedge clk);
    instr_address = 32'hBFC0_0014;
    @(negedge clk);
    instr_address = 32'hBFC0_0018;
    @(negedge clk);
    instr_address = '0;
    drain("rerun");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
